sb_commit_queue: RTL and testbench
==================================

# sb_commit_queue

In-order issue/commit tracking queue sitting directly downstream of the issue stage and upstream of the commit stage of the 32-bit, single-commit-port, FPGA-targeted core configuration (four scoreboard entries, one commit port). It allocates a transaction ID per issued instruction and captures out-of-order writeback results. It presents completed instructions to commit strictly in program order, one per cycle. Flush discards all in-flight entries.

## Interface
- NR_ENTRIES, 4, number of entries; power of two, at least 2
- XLEN, 32, datapath width
- TRANS_ID_BITS, $clog2(NR_ENTRIES), transaction ID width
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous and active-high
- flush_i  in  1  discard all entries
- issue_valid_i  in  1  issue stage offers an instruction
- issue_ready_o  out  1  queue can accept (not full)
- issue_pc_i  in  XLEN  instruction PC
- issue_rd_i  in  5  destination register index
- issue_trans_id_o  out  TRANS_ID_BITS  ID assigned to the offered instruction (current tail index)
- wb_valid_i  in  1  functional unit writeback
- wb_trans_id_i  in  TRANS_ID_BITS  entry being written back
- wb_result_i  in  XLEN  result value
- wb_exception_i  in  1  instruction raised an exception
- commit_valid_o  out  1  head entry is complete
- commit_ack_i  in  1  commit stage retires head
- commit_pc_o  out  XLEN  head PC
- commit_rd_o  out  5  head rd
- commit_result_o  out  XLEN  head result
- commit_exception_o  out  1  head exception flag
- count_o  out  $clog2(NR_ENTRIES+1)  occupied entries

## Operation
- Per entry: issued, done, pc, rd, result, ex. Head and tail pointers are TRANS_ID_BITS+1 wide. The extra wrap bit distinguishes full from empty.
- The queue is empty when head == tail and full when the index bits are equal and the wrap bits differ. count_o = tail - head, computed modulo 2^(TRANS_ID_BITS+1).
- issue_ready_o = !full. It is combinational from registered pointers only and does not depend on commit_ack_i in the same cycle (no full-bypass).
- issue_trans_id_o = tail index bits, always driven.
- Issue fire (issue_valid_i & issue_ready_o): entry[tail] gets issued=1, done=0, ex=0, pc and rd stored; tail increments with wrap.
- Writeback: if entry[wb_trans_id_i].issued is set at the start of the cycle, the entry gets done=1 and result/ex are stored.
  - Writeback to a non-issued entry is ignored.
  - A writeback in the cycle that entry is being issued is ignored.
  - A repeated writeback to a done entry overwrites result/ex.
- commit_valid_o = entry[head].issued & entry[head].done, taken from registered state. commit_* data outputs come from entry[head].
- Commit fire (commit_valid_o & commit_ack_i): entry[head].issued is cleared and head increments with wrap. commit_ack_i without commit_valid_o is ignored.
- Simultaneous issue and commit: both take effect and count_o is unchanged.
- Flush has priority over issue, writeback and commit in the same cycle. It clears all issued/done bits and sets head = tail = 0. Data fields are retained.
- Reset has the same effect as flush and additionally zeroes all data fields.
- Reset values: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0, commit_pc_o=0, commit_rd_o=0, commit_result_o=0, commit_exception_o=0, count_o=0.

## Timing
- Issue in cycle N makes the entry visible as issued from N+1. The earliest accepted writeback is in N+1, and the earliest commit_valid_o is in N+2.
- Writeback to the head entry in cycle M raises commit_valid_o in M+1 (no wb-to-commit bypass).
- One commit per cycle at most, at a sustained rate of 1/cycle when head entries are done.
- After a flush or reset in cycle F: from F+1, commit_valid_o=0, issue_ready_o=1, count_o=0.
- An issue or commit presented in cycle F is dropped; a writeback in F+1 to a pre-flush ID is ignored.

## Test plan
- Reset, then idle -> issue_ready_o=1, commit_valid_o=0, count_o=0, issue_trans_id_o=0.
- Issue 4 instructions (pc 0x100..0x10C) with no writeback -> IDs 0,1,2,3; count_o=4; issue_ready_o=0. A fifth issue_valid_i is not accepted and tail stays put.
- Writeback IDs in order 2,0,3,1 (results 0xA2,0xA0,0xA3,0xA1) with commit_ack_i held high:
  - commit_valid_o rises the cycle after ID0 writes back;
  - commits occur in order pc 0x100 (0xA0), then 0x104 only after ID1 writes back, then 0x108 and 0x10C on consecutive cycles.
- Full queue, head done, commit_ack_i=1 and issue_valid_i=1 in the same cycle -> commit happens and the issue is refused. The next cycle accepts the issue with trans_id equal to the old head index (wrap). count_o returns to 4.
- Writeback to an unissued ID, and writeback in the same cycle as that ID's issue -> no done bit set and commit_valid_o stays 0.
- 3 entries in flight with writeback, commit_ack and issue all asserted together with flush_i -> next cycle count_o=0, commit_valid_o=0, issue_trans_id_o=0. A later writeback to ID 1 is ignored.

Source files
------------

// File: rtl/sb_commit_queue.sv
// In-order issue/commit tracking queue: allocates transaction IDs at issue, captures
// out-of-order writebacks and hands completed entries to commit in program order.
module sb_commit_queue #(
   parameter int NR_ENTRIES    = 4,
   parameter int XLEN          = 32,
   parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             flush_i,
   input  logic                             issue_valid_i,
   output logic                             issue_ready_o,
   input  logic [XLEN-1:0]                  issue_pc_i,
   input  logic [4:0]                       issue_rd_i,
   output logic [TRANS_ID_BITS-1:0]         issue_trans_id_o,
   input  logic                             wb_valid_i,
   input  logic [TRANS_ID_BITS-1:0]         wb_trans_id_i,
   input  logic [XLEN-1:0]                  wb_result_i,
   input  logic                             wb_exception_i,
   output logic                             commit_valid_o,
   input  logic                             commit_ack_i,
   output logic [XLEN-1:0]                  commit_pc_o,
   output logic [4:0]                       commit_rd_o,
   output logic [XLEN-1:0]                  commit_result_o,
   output logic                             commit_exception_o,
   output logic [$clog2(NR_ENTRIES+1)-1:0]  count_o
);

   localparam int PTR_W = TRANS_ID_BITS + 1;
   localparam int CNT_W = $clog2(NR_ENTRIES + 1);

   logic [NR_ENTRIES-1:0] issued_q, issued_d;
   logic [NR_ENTRIES-1:0] done_q, done_d;
   logic [NR_ENTRIES-1:0] ex_q, ex_d;
   logic [XLEN-1:0]       pc_q [NR_ENTRIES];
   logic [XLEN-1:0]       pc_d [NR_ENTRIES];
   logic [XLEN-1:0]       result_q [NR_ENTRIES];
   logic [XLEN-1:0]       result_d [NR_ENTRIES];
   logic [4:0]            rd_q [NR_ENTRIES];
   logic [4:0]            rd_d [NR_ENTRIES];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;

   logic [TRANS_ID_BITS-1:0] head_idx;
   logic [TRANS_ID_BITS-1:0] tail_idx;
   logic [PTR_W-1:0]         ptr_diff;
   logic                     full;
   logic                     issue_fire;
   logic                     commit_fire;
   logic                     wb_fire;

   assign head_idx = head_q[TRANS_ID_BITS-1:0];
   assign tail_idx = tail_q[TRANS_ID_BITS-1:0];
   assign ptr_diff = tail_q - head_q;
   assign full     = (head_idx == tail_idx) && (head_q[TRANS_ID_BITS] != tail_q[TRANS_ID_BITS]);

   // Ready looks only at registered pointers, so a full queue refuses issue even while retiring.
   assign issue_ready_o      = ~full;
   assign issue_trans_id_o   = tail_idx;
   assign count_o            = CNT_W'(ptr_diff);
   assign commit_valid_o     = issued_q[head_idx] & done_q[head_idx];
   assign commit_pc_o        = pc_q[head_idx];
   assign commit_rd_o        = rd_q[head_idx];
   assign commit_result_o    = result_q[head_idx];
   assign commit_exception_o = ex_q[head_idx];

   assign issue_fire  = issue_valid_i & ~full;
   assign commit_fire = commit_valid_o & commit_ack_i;
   // The tail slot is never issued while not full, so same-cycle issue+writeback is dropped here.
   assign wb_fire     = wb_valid_i & issued_q[wb_trans_id_i];

   always_comb begin
      issued_d = issued_q;
      done_d   = done_q;
      ex_d     = ex_q;
      pc_d     = pc_q;
      rd_d     = rd_q;
      result_d = result_q;
      head_d   = head_q;
      tail_d   = tail_q;

      if (flush_i) begin
         issued_d = '0;
         done_d   = '0;
         head_d   = '0;
         tail_d   = '0;
      end else begin
         if (wb_fire) begin
            done_d[wb_trans_id_i]   = 1'b1;
            ex_d[wb_trans_id_i]     = wb_exception_i;
            result_d[wb_trans_id_i] = wb_result_i;
         end
         if (commit_fire) begin
            issued_d[head_idx] = 1'b0;
            head_d             = head_q + PTR_W'(1);
         end
         if (issue_fire) begin
            issued_d[tail_idx] = 1'b1;
            done_d[tail_idx]   = 1'b0;
            ex_d[tail_idx]     = 1'b0;
            pc_d[tail_idx]     = issue_pc_i;
            rd_d[tail_idx]     = issue_rd_i;
            tail_d             = tail_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         issued_q <= '0;
         done_q   <= '0;
         ex_q     <= '0;
         pc_q     <= '{default: '0};
         rd_q     <= '{default: '0};
         result_q <= '{default: '0};
         head_q   <= '0;
         tail_q   <= '0;
      end else begin
         issued_q <= issued_d;
         done_q   <= done_d;
         ex_q     <= ex_d;
         pc_q     <= pc_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
      end
   end

endmodule

// File: tb/tb_sb_commit_queue.sv
// Directed bench for sb_commit_queue: a behavioural queue model predicts handshakes each
// cycle and a scoreboard of issued instructions is checked against every commit.
module tb_sb_commit_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        issue_valid;
   logic        issue_ready;
   logic [31:0] issue_pc;
   logic [4:0]  issue_rd;
   logic [1:0]  issue_trans_id;
   logic        wb_valid;
   logic [1:0]  wb_trans_id;
   logic [31:0] wb_result;
   logic        wb_exception;
   logic        commit_valid;
   logic        commit_ack;
   logic [31:0] commit_pc;
   logic [4:0]  commit_rd;
   logic [31:0] commit_result;
   logic        commit_exception;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [1:0]  id;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   bit          m_issued [4];
   bit          m_done [4];
   bit          m_ex [4];
   logic [31:0] m_res [4];
   logic [2:0]  m_head;
   logic [2:0]  m_tail;

   always #5 clk = ~clk;

   sb_commit_queue #(.NR_ENTRIES(4), .XLEN(32)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .flush_i            (flush),
      .issue_valid_i      (issue_valid),
      .issue_ready_o      (issue_ready),
      .issue_pc_i         (issue_pc),
      .issue_rd_i         (issue_rd),
      .issue_trans_id_o   (issue_trans_id),
      .wb_valid_i         (wb_valid),
      .wb_trans_id_i      (wb_trans_id),
      .wb_result_i        (wb_result),
      .wb_exception_i     (wb_exception),
      .commit_valid_o     (commit_valid),
      .commit_ack_i       (commit_ack),
      .commit_pc_o        (commit_pc),
      .commit_rd_o        (commit_rd),
      .commit_result_o    (commit_result),
      .commit_exception_o (commit_exception),
      .count_o            (count)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input bit fl, input bit iv, input logic [31:0] pc,
                                 input logic [4:0] rd, input bit wv, input logic [1:0] wid,
                                 input logic [31:0] wres, input bit wex, input bit ack);
      flush        = fl;
      issue_valid  = iv;
      issue_pc     = pc;
      issue_rd     = rd;
      wb_valid     = wv;
      wb_trans_id  = wid;
      wb_result    = wres;
      wb_exception = wex;
      commit_ack   = ack;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_issued[i] = 1'b0;
         m_done[i]   = 1'b0;
      end
      m_head = '0;
      m_tail = '0;
      sb_q.delete();
   endtask

   // Compare DUT against the model for the current cycle, then advance the model and the clock.
   task automatic tick();
      logic [1:0] h;
      logic [1:0] t;
      bit         m_full;
      bit         cv;
      bit         wb_ok;
      bit         ifire;
      sb_entry_t  e;
      #1;
      h      = m_head[1:0];
      t      = m_tail[1:0];
      m_full = ((m_tail - m_head) == 3'd4);
      cv     = m_issued[h] && m_done[h];
      check_output("commit_valid", {31'd0, commit_valid}, {31'd0, cv});
      check_output("issue_ready", {31'd0, issue_ready}, {31'd0, !m_full});
      check_output("count", {29'd0, count}, {29'd0, m_tail - m_head});
      check_output("issue_trans_id", {30'd0, issue_trans_id}, {30'd0, t});
      if (flush) begin
         model_clear();
      end else begin
         wb_ok = wb_valid && m_issued[wb_trans_id];
         ifire = issue_valid && !m_full;
         if (cv && commit_ack) begin
            if (sb_q.size() == 0) begin
               check_output("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check_output("commit_id", {30'd0, h}, {30'd0, e.id});
               check_output("commit_pc", commit_pc, e.pc);
               check_output("commit_rd", {27'd0, commit_rd}, {27'd0, e.rd});
               check_output("commit_result", commit_result, m_res[e.id]);
               check_output("commit_exception", {31'd0, commit_exception}, {31'd0, m_ex[e.id]});
            end
            m_issued[h] = 1'b0;
            m_head      = m_head + 3'd1;
         end
         if (wb_ok) begin
            m_done[wb_trans_id] = 1'b1;
            m_res[wb_trans_id]  = wb_result;
            m_ex[wb_trans_id]   = wb_exception;
         end
         if (ifire) begin
            m_issued[t] = 1'b1;
            m_done[t]   = 1'b0;
            m_ex[t]     = 1'b0;
            sb_q.push_back('{pc: issue_pc, rd: issue_rd, id: t});
            m_tail = m_tail + 3'd1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input bit ack);
      apply_stimulus(0, 0, 32'd0, 5'd0, 0, 2'd0, 32'd0, 0, ack);
      tick();
   endtask

   initial begin
      logic [1:0] t;
      logic [1:0] u;
      rst = 1'b1;
      apply_stimulus(0, 0, 32'd0, 5'd0, 0, 2'd0, 32'd0, 0, 0);
      model_clear();
      for (int i = 0; i < 4; i++) begin
         m_ex[i]  = 1'b0;
         m_res[i] = 32'd0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      #1;
      check_output("reset_commit_pc", commit_pc, 32'd0);
      check_output("reset_commit_rd", {27'd0, commit_rd}, 32'd0);
      check_output("reset_commit_result", commit_result, 32'd0);
      check_output("reset_commit_exception", {31'd0, commit_exception}, 32'd0);
      idle(0);
      idle(0);

      // Fill the queue, then offer a fifth instruction that must be refused
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(0, 1, 32'h100 + 32'(4 * i), 5'(i + 1), 0, 2'd0, 32'd0, 0, 0);
         tick();
      end
      apply_stimulus(0, 1, 32'h200, 5'd9, 0, 2'd0, 32'd0, 0, 0);
      tick();
      idle(0);

      // Out-of-order writebacks 2,0,3,1 with commit acknowledged throughout
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd2, 32'hA2, 0, 1);
      tick();
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd0, 32'hA0, 0, 1);
      tick();
      check_output("first_commit_valid", {31'd0, commit_valid}, 32'd1);
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd3, 32'hA3, 1, 1);
      tick();
      check_output("head1_not_done", {31'd0, commit_valid}, 32'd0);
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd1, 32'hA1, 0, 1);
      tick();
      idle(1);
      idle(1);
      idle(1);
      idle(0);

      // Full queue: commit frees a slot but the same-cycle issue is refused
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(0, 1, 32'h300 + 32'(4 * i), 5'(i + 10), 0, 2'd0, 32'd0, 0, 0);
         tick();
      end
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd0, 32'hB0, 0, 0);
      tick();
      apply_stimulus(0, 1, 32'h400, 5'd20, 0, 2'd0, 32'd0, 0, 1);
      tick();
      check_output("wrap_trans_id", {30'd0, issue_trans_id}, 32'd0);
      apply_stimulus(0, 1, 32'h400, 5'd20, 0, 2'd0, 32'd0, 0, 0);
      tick();
      check_output("refill_count", {29'd0, count}, 32'd4);
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd1, 32'hB1, 0, 0);
      tick();
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd2, 32'hB2, 1, 0);
      tick();
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd3, 32'hB3, 0, 0);
      tick();
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd0, 32'hC0, 0, 0);
      tick();
      repeat (5) idle(1);

      // Writeback to an unissued ID, then writeback in the same cycle as the issue
      t = m_tail[1:0];
      u = t + 2'd1;
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, u, 32'hBAD, 1, 1);
      tick();
      apply_stimulus(0, 1, 32'h480, 5'd7, 1, t, 32'hBAD, 1, 1);
      tick();
      check_output("same_cycle_wb_ignored", {31'd0, commit_valid}, 32'd0);
      idle(1);
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, t, 32'hD0, 0, 1);
      tick();
      idle(1);
      idle(0);

      // Flush with everything else asserted in the same cycle
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(0, 1, 32'h500 + 32'(4 * i), 5'(i + 3), 0, 2'd0, 32'd0, 0, 0);
         tick();
      end
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, m_head[1:0], 32'hE0, 0, 0);
      tick();
      apply_stimulus(1, 1, 32'h600, 5'd30, 1, m_head[1:0] + 2'd1, 32'hE1, 0, 1);
      tick();
      check_output("flush_count", {29'd0, count}, 32'd0);
      check_output("flush_commit_valid", {31'd0, commit_valid}, 32'd0);
      check_output("flush_trans_id", {30'd0, issue_trans_id}, 32'd0);
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd1, 32'hE2, 0, 1);
      tick();
      apply_stimulus(0, 1, 32'h700, 5'd4, 0, 2'd0, 32'd0, 0, 0);
      tick();
      apply_stimulus(0, 1, 32'h704, 5'd5, 0, 2'd0, 32'd0, 0, 0);
      tick();
      apply_stimulus(0, 0, 32'd0, 5'd0, 1, 2'd0, 32'hF0, 0, 1);
      tick();
      idle(1);
      check_output("post_flush_wb_ignored", {31'd0, commit_valid}, 32'd0);
      idle(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
